rgmii_rx_inband_status: RTL and testbench
=========================================

Name: rgmii_rx_inband_status

Overview:
Decodes RGMII in-band link status from the receive interface during inter-frame gaps. Requires several consecutive identical samples before accepting a new status. Produces the qualified one-hot speed and link flags that the transmit clock manager consumes (its rx_speed_10/100/1000 and rx_link_up inputs). Sits in the RX clock domain directly after the DDR input capture, which supplies the rising-edge nibble.

Parameters:
- SKIP_CYCLES, 2: consecutive inter-frame cycles ignored after any non-IFG cycle, before sampling starts.
- MATCH_COUNT, 8: identical valid samples required to commit a status (minimum 1).
- STALE_TIMEOUT, 65535: consecutive non-IFG cycles that force link down; 0 disables.

Ports:
- clk, in, 1: RX clock (2.5/25/125 MHz).
- reset_n, in, 1: asynchronous, active-low reset.
- rx_dv, in, 1: rising-edge RX_CTL (data valid).
- rx_er, in, 1: RX_DV XOR falling-edge RX_CTL (error).
- rxd, in, 4: rising-edge RXD nibble.
- rx_speed_10, out, 1: committed speed is 10 Mb/s.
- rx_speed_100, out, 1: committed speed is 100 Mb/s.
- rx_speed_1000, out, 1: committed speed is 1000 Mb/s.
- rx_link_up, out, 1: committed link status.
- rx_full_duplex, out, 1: committed duplex.
- status_changed, out, 1: one-cycle pulse on any committed change.
- qualifying, out, 1: high while a candidate status is being counted.
- status_err_count, out, 16: saturating error count (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - rx_speed_1000=1, rx_speed_10=0, rx_speed_100=0.
  - rx_link_up=0, rx_full_duplex=0.
  - status_changed=0, qualifying=0, status_err_count=0.
  - state=S_WAIT_IFG, all counters 0.
- ifg = !rx_dv && !rx_er. Carrier extension and false carrier (rx_er=1) are never IFG.
- Sample decode: link=rxd[0], speed code=rxd[2:1] (00=10, 01=100, 10=1000, 11=reserved/invalid), duplex=rxd[3].
- skip_cnt counts consecutive IFG cycles and saturates at SKIP_CYCLES. A cycle is "sampled" only when ifg=1 and skip_cnt==SKIP_CYCLES on entry to that cycle. Any non-IFG cycle clears skip_cnt.
- States:
  - S_WAIT_IFG: on a sampled valid cycle, load the candidate {link, speed, duplex}, set match_cnt=1, go to S_QUALIFY.
  - S_QUALIFY: qualifying=1.
    - Sampled sample equal to the candidate: match_cnt++.
    - Sampled sample different but valid: reload the candidate, match_cnt=1.
    - Non-IFG cycle: go to S_WAIT_IFG; outputs are unchanged.
  - S_STABLE: a sampled valid sample differing from the committed outputs loads a candidate with match_cnt=1 and goes to S_QUALIFY. Non-IFG cycles keep S_STABLE.
- Commit: on the cycle match_cnt reaches MATCH_COUNT (including the load cycle when MATCH_COUNT=1), go to S_STABLE. Outputs update on the next edge.
  - status_changed pulses in the same cycle as the output update, only if any of {speed, link, duplex} differ.
  - Latency from the first matching sample to output change is MATCH_COUNT cycles.
- Reserved speed code (11) on a sampled cycle: the sample is invalid. The candidate is discarded; in S_QUALIFY go to S_WAIT_IFG with skip_cnt kept at saturation, so the next IFG cycle samples again. Outputs are unchanged.
- Speed outputs are always exactly one-hot, including across a commit.
- Stale timeout: stale_cnt increments on non-IFG cycles and clears on IFG cycles. When stale_cnt reaches STALE_TIMEOUT (and STALE_TIMEOUT != 0):
  - rx_link_up is forced to 0; speed and duplex are retained.
  - status_changed pulses only if link was 1.
  - state=S_WAIT_IFG; stale_cnt holds at saturation until the next IFG cycle.
- Simultaneous timeout and commit cannot occur, because a commit requires an IFG cycle.
- Counter widths: $clog2(MAX+1) of each parameter.

Optional Feature:
- Macro: RX_INBAND_ERROR_COUNT_EN.
- With the macro defined: status_err_count is a 16-bit saturating (at 16'hFFFF) count, incremented by 1 on each sampled reserved-code cycle and each S_QUALIFY abort caused by a non-IFG cycle. Both events in one cycle are impossible.
- Without the macro: status_err_count is tied to 16'h0000 and no counter logic is instantiated.

Decomposition:
- Package eth_rgmii_pkg holds:
  - speed code localparams (SPD_10=2'b00, SPD_100=2'b01, SPD_1000=2'b10, SPD_RSVD=2'b11);
  - the inband_status_t packed struct {duplex, speed[1:0], link};
  - the state enum {S_WAIT_IFG, S_QUALIFY, S_STABLE}.
- Single module; no sub-module is natural.

Test Plan:
- Reset, then 12 IFG cycles with rxd=4'b1101 (defaults) -> speed_1000=1, link 0 -> 1, duplex=1.
  - status_changed pulses once, exactly 2+8 sampled-window cycles after the IFG starts.
  - qualifying is high for 7 cycles.
- Committed 1000/up, then IFG rxd=4'b0011 for 8 samples -> speed_100=1, speed_1000=0 in the same cycle, one status_changed pulse, never zero-hot or two-hot.
- Candidate 0011 interrupted by rx_dv=1 after 5 samples, then 10 IFG cycles of 0011 -> no change until 8 fresh samples after 2 skip cycles.
  - With RX_INBAND_ERROR_COUNT_EN defined, status_err_count=1.
- IFG rxd=4'b0111 (reserved) for 20 cycles while committed 100/up -> outputs unchanged, qualifying stays 0.
  - With RX_INBAND_ERROR_COUNT_EN defined, count=18.
- STALE_TIMEOUT=50, link up, then rx_dv=1 continuously for 60 cycles -> rx_link_up falls on cycle 50 with one pulse, speed retained; link recovers after IFG plus 8 samples.
- reset_n asserted asynchronously mid-S_QUALIFY (between edges) -> outputs return to reset values immediately, before the next clk edge; qualification restarts after release.

Source files
------------

// File: rtl/eth_rgmii_pkg.sv
// rtl/eth_rgmii_pkg.sv - RGMII in-band status speed codes, sample struct and FSM states
package eth_rgmii_pkg;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;
  localparam logic [1:0] SPD_RSVD = 2'b11;

  // Field order mirrors the IFG nibble: rxd[3]=duplex, rxd[2:1]=speed, rxd[0]=link.
  typedef struct packed {
    logic       duplex;
    logic [1:0] speed;
    logic       link;
  } inband_status_t;

  typedef enum logic [1:0] {
    S_WAIT_IFG,
    S_QUALIFY,
    S_STABLE
  } state_t;

endpackage

// File: rtl/rgmii_rx_inband_status.sv
// rtl/rgmii_rx_inband_status.sv - qualified RGMII in-band link status decoder
// Optional macro RX_INBAND_ERROR_COUNT_EN enables the saturating status error counter.
module rgmii_rx_inband_status
  import eth_rgmii_pkg::*;
#(
  parameter int SKIP_CYCLES   = 2,
  parameter int MATCH_COUNT   = 8,
  parameter int STALE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [3:0]  rxd,
  output logic        rx_speed_10,
  output logic        rx_speed_100,
  output logic        rx_speed_1000,
  output logic        rx_link_up,
  output logic        rx_full_duplex,
  output logic        status_changed,
  output logic        qualifying,
  output logic [15:0] status_err_count
);

  localparam int SKIP_W  = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;
  localparam int MATCH_W = (MATCH_COUNT > 1) ? $clog2(MATCH_COUNT + 1) : 1;
  localparam int STALE_W = (STALE_TIMEOUT > 0) ? $clog2(STALE_TIMEOUT + 1) : 1;

  localparam logic [SKIP_W-1:0]  SKIP_MAX   = SKIP_W'(SKIP_CYCLES);
  localparam logic [SKIP_W-1:0]  SKIP_ONE   = SKIP_W'(1);
  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(MATCH_COUNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE  = MATCH_W'(1);
  localparam logic [STALE_W-1:0] STALE_MAX  = STALE_W'(STALE_TIMEOUT);
  localparam logic [STALE_W-1:0] STALE_LAST = STALE_W'((STALE_TIMEOUT > 0) ? STALE_TIMEOUT - 1 : 0);
  localparam logic [STALE_W-1:0] STALE_ONE  = STALE_W'(1);

  state_t               r_state;
  inband_status_t       r_status;
  inband_status_t       r_cand;
  logic [SKIP_W-1:0]    r_skip_cnt;
  logic [MATCH_W-1:0]   r_match_cnt;
  logic [STALE_W-1:0]   r_stale_cnt;
  logic                 r_changed;
  logic                 r_qualifying;

  inband_status_t       w_sample;
  logic                 w_ifg;
  logic                 w_sampled;
  logic                 w_valid;
  logic                 w_stale_hit;
  logic                 w_load;
  logic                 w_inc;
  logic                 w_commit;
  logic                 w_abort;

  assign w_sample    = inband_status_t'(rxd);
  assign w_ifg       = !rx_dv && !rx_er;
  assign w_sampled   = w_ifg && (r_skip_cnt == SKIP_MAX);
  assign w_valid     = (w_sample.speed != SPD_RSVD);
  assign w_stale_hit = (STALE_TIMEOUT != 0) && !w_ifg && (r_stale_cnt == STALE_LAST);

  always_comb begin
    w_load   = 1'b0;
    w_inc    = 1'b0;
    w_commit = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      S_WAIT_IFG: w_load = w_sampled && w_valid;
      S_QUALIFY: begin
        if (!w_ifg || (w_sampled && !w_valid)) begin
          w_abort = 1'b1;
        end else if (w_sampled) begin
          if (w_sample == r_cand) begin
            if (r_match_cnt == MATCH_LAST) w_commit = 1'b1;
            else                           w_inc    = 1'b1;
          end else begin
            w_load = 1'b1;
          end
        end
      end
      S_STABLE:   w_load = w_sampled && w_valid && (w_sample != r_status);
      default:    w_abort = 1'b1;
    endcase
    // A single matching sample is already enough to commit.
    if (w_load && (MATCH_COUNT == 1)) w_commit = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skip_cnt  <= '0;
      r_stale_cnt <= '0;
    end else begin
      if (!w_ifg)                      r_skip_cnt <= '0;
      else if (r_skip_cnt != SKIP_MAX) r_skip_cnt <= r_skip_cnt + SKIP_ONE;
      if (w_ifg)                        r_stale_cnt <= '0;
      else if (r_stale_cnt != STALE_MAX) r_stale_cnt <= r_stale_cnt + STALE_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_WAIT_IFG;
      r_status     <= '{duplex: 1'b0, speed: SPD_1000, link: 1'b0};
      r_cand       <= '{duplex: 1'b0, speed: SPD_1000, link: 1'b0};
      r_match_cnt  <= '0;
      r_changed    <= 1'b0;
      r_qualifying <= 1'b0;
    end else begin
      r_changed <= 1'b0;
      if (w_stale_hit) begin
        r_status.link <= 1'b0;
        r_changed     <= r_status.link;
        r_state       <= S_WAIT_IFG;
        r_qualifying  <= 1'b0;
      end else if (w_commit) begin
        r_status     <= w_sample;
        r_changed    <= (w_sample != r_status);
        r_match_cnt  <= '0;
        r_state      <= S_STABLE;
        r_qualifying <= 1'b0;
      end else if (w_load) begin
        r_cand       <= w_sample;
        r_match_cnt  <= MATCH_ONE;
        r_state      <= S_QUALIFY;
        r_qualifying <= 1'b1;
      end else if (w_inc) begin
        r_match_cnt  <= r_match_cnt + MATCH_ONE;
      end else if (w_abort) begin
        r_state      <= S_WAIT_IFG;
        r_qualifying <= 1'b0;
      end
    end
  end

  // Committed speed is never the reserved code, so this decode stays one-hot.
  assign rx_speed_10    = (r_status.speed == SPD_10);
  assign rx_speed_100   = (r_status.speed == SPD_100);
  assign rx_speed_1000  = (r_status.speed == SPD_1000);
  assign rx_link_up     = r_status.link;
  assign rx_full_duplex = r_status.duplex;
  assign status_changed = r_changed;
  assign qualifying     = r_qualifying;

`ifdef RX_INBAND_ERROR_COUNT_EN
  logic [15:0] r_err_cnt;
  logic        w_err_evt;

  assign w_err_evt = ((r_state == S_QUALIFY) && !w_ifg) || (w_sampled && !w_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                              r_err_cnt <= 16'h0000;
    else if (w_err_evt && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
  end

  assign status_err_count = r_err_cnt;
`else
  assign status_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_rgmii_rx_inband_status.sv
// tb/tb_rgmii_rx_inband_status.sv - directed self-checking bench for rgmii_rx_inband_status
module tb_rgmii_rx_inband_status;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic        rx_er = 1'b0;
  logic [3:0]  rxd = 4'h0;

  logic        spd10, spd100, spd1000, link, fdx, chg, qual;
  logic [15:0] errc;
  logic        s_spd10, s_spd100, s_spd1000, s_link, s_fdx, s_chg, s_qual;
  logic [15:0] s_errc;

  int checks = 0;
  int errors = 0;
  int n_chg, idx_chg, n_qual, n_s_chg, idx_s_chg, idx_fall;
  int exp_err;

  always #5 clk = ~clk;

  rgmii_rx_inband_status u_dut (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .rx_speed_10(spd10), .rx_speed_100(spd100), .rx_speed_1000(spd1000),
    .rx_link_up(link), .rx_full_duplex(fdx), .status_changed(chg),
    .qualifying(qual), .status_err_count(errc)
  );

  rgmii_rx_inband_status #(.STALE_TIMEOUT(50)) u_stale (
    .clk(clk), .reset_n(reset_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
    .rx_speed_10(s_spd10), .rx_speed_100(s_spd100), .rx_speed_1000(s_spd1000),
    .rx_link_up(s_link), .rx_full_duplex(s_fdx), .status_changed(s_chg),
    .qualifying(s_qual), .status_err_count(s_errc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input logic dv, input logic er, input logic [3:0] d);
    rx_dv = dv;
    rx_er = er;
    rxd   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_err(input string tag, input int expected);
`ifdef RX_INBAND_ERROR_COUNT_EN
    check(tag, {16'h0, errc}, expected);
`else
    check(tag, {16'h0, errc}, 0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_spd"}, {spd10, spd100, spd1000}, 3'b001);
    check({tag, "_link"}, link, 1'b0);
    check({tag, "_fdx"}, fdx, 1'b0);
    check({tag, "_chg"}, chg, 1'b0);
    check({tag, "_qual"}, qual, 1'b0);
    check({tag, "_err"}, {16'h0, errc}, 0);
  endtask

  task automatic run_ifg_commit(input string tag, input logic [3:0] d, input int n,
                                output int cnt, output int idx, output int qcnt);
    cnt = 0; idx = -1; qcnt = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, d);
      if (chg) begin cnt++; idx = i; end
      if (qual) qcnt++;
    end
  endtask

  initial begin
    rx_dv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;

    // 2 skip cycles, then 8 samples: commit seen after the 10th IFG cycle.
    run_ifg_commit("t1", 4'b1101, 12, n_chg, idx_chg, n_qual);
    check("t1_pulses", n_chg, 1);
    check("t1_pulse_idx", idx_chg, 9);
    check("t1_qual_cycles", n_qual, 7);
    check("t1_spd", {spd10, spd100, spd1000}, 3'b001);
    check("t1_link", link, 1'b1);
    check("t1_fdx", fdx, 1'b1);

    // Skip counter already saturated: 8 back-to-back samples commit 100 Mb/s.
    n_chg = 0; idx_chg = -1;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 4'b0011);
      check("t2_onehot", $countones({spd10, spd100, spd1000}), 1);
      if (chg) begin n_chg++; idx_chg = i; end
    end
    check("t2_pulses", n_chg, 1);
    check("t2_pulse_idx", idx_chg, 7);
    check("t2_spd", {spd10, spd100, spd1000}, 3'b010);
    check("t2_fdx", fdx, 1'b0);

    run_ifg_commit("t3pre", 4'b1101, 8, n_chg, idx_chg, n_qual);
    check("t3pre_idx", idx_chg, 7);
    check("t3pre_spd", {spd10, spd100, spd1000}, 3'b001);

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 4'b0011);
    check("t3_qual_mid", qual, 1'b1);
    check("t3_spd_mid", {spd10, spd100, spd1000}, 3'b001);
    cyc(1'b1, 1'b0, 4'b0011);
    check("t3_qual_abort", qual, 1'b0);
    exp_err = 1;
    check_err("t3_err", exp_err);
    run_ifg_commit("t3", 4'b0011, 10, n_chg, idx_chg, n_qual);
    check("t3_pulses", n_chg, 1);
    check("t3_pulse_idx", idx_chg, 9);
    check("t3_spd", {spd10, spd100, spd1000}, 3'b010);
    check("t3_link", link, 1'b1);

    // Reserved speed code: 2 skip cycles, then 18 invalid samples.
    cyc(1'b1, 1'b0, 4'b0011);
    run_ifg_commit("t4", 4'b0111, 20, n_chg, idx_chg, n_qual);
    check("t4_pulses", n_chg, 0);
    check("t4_qual", n_qual, 0);
    check("t4_spd", {spd10, spd100, spd1000}, 3'b010);
    check("t4_link", link, 1'b1);
    exp_err = exp_err + 18;
    check_err("t4_err", exp_err);

    // Stale timeout on the STALE_TIMEOUT=50 instance.
    check("t5_link_pre", s_link, 1'b1);
    n_s_chg = 0; idx_fall = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1, 1'b0, 4'b0000);
      if (s_chg) n_s_chg++;
      if (!s_link && idx_fall < 0) idx_fall = i;
    end
    check("t5_fall_idx", idx_fall, 49);
    check("t5_pulses", n_s_chg, 1);
    check("t5_spd_kept", {s_spd10, s_spd100, s_spd1000}, 3'b010);
    check("t5_main_link", link, 1'b1);
    n_s_chg = 0; idx_s_chg = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 4'b0011);
      if (s_chg) begin n_s_chg++; idx_s_chg = i; end
    end
    check("t5_recover_idx", idx_s_chg, 9);
    check("t5_recover_pulses", n_s_chg, 1);
    check("t5_recover_link", s_link, 1'b1);
    check_err("t5_err", exp_err);

    // Asynchronous reset while qualifying a new candidate.
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 4'b1101);
    check("t6_qual_pre", qual, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_ifg_commit("t6", 4'b1101, 12, n_chg, idx_chg, n_qual);
    check("t6_pulse_idx", idx_chg, 9);
    check("t6_qual_cycles", n_qual, 7);
    check("t6_link", link, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
